// File: rtl/fetch_pkg.sv
// Shared types and helpers for the queued fetch stage: the {pc, instr} queue
// entry, the instruction size and PC alignment.
package fetch_pkg;

    localparam int FETCH_WORD  = 32;
    localparam int INSTR_BYTES = 4;

    typedef struct packed {
        logic [FETCH_WORD-1:0] pc;
        logic [FETCH_WORD-1:0] instr;
    } fetch_entry_t;

    // Redirect targets may be misaligned; fetch always restarts on a word boundary.
    function automatic logic [FETCH_WORD-1:0] align_pc(input logic [FETCH_WORD-1:0] addr);
        return {addr[FETCH_WORD-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queued_if.sv
// Fetch-to-decode/memory-stage signal bundle. The master side is the fetch stage,
// the slave side is the decode/memory pipeline around it.
interface fetch_queued_if #(
    parameter int WORD   = 32,
    parameter int QDEPTH = 4
);
    logic                        PCSrcM;
    logic [WORD-1:0]             pcM;
    logic                        stallD;
    logic [WORD-1:0]             pcD;
    logic [WORD-1:0]             instrD;
    logic                        validD;
    logic [$clog2(QDEPTH+1)-1:0] occupancy;

    modport master (
        input  PCSrcM, pcM, stallD,
        output pcD, instrD, validD, occupancy
    );

    modport slave (
        output PCSrcM, pcM, stallD,
        input  pcD, instrD, validD, occupancy
    );
endinterface

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch entries. Flush outranks push and pop; the head entry
// is read straight from its storage register.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int QDEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush,
    input  logic                        push,
    input  logic                        pop,
    input  fetch_entry_t                din,
    output fetch_entry_t                head,
    output logic [$clog2(QDEPTH+1)-1:0] count
);
    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = $clog2(QDEPTH+1);

    fetch_entry_t     mem_r [QDEPTH];
    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [CNT_W-1:0] count_r;

    // Pointer and occupancy bookkeeping; pointers wrap naturally at power-of-two depth.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else if (flush) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else begin
            tail_r <= push ? tail_r + PTR_W'(1) : tail_r;
            head_r <= pop  ? head_r + PTR_W'(1) : head_r;
            case ({push, pop})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; a push into a full queue lands on the slot being popped.
    always_ff @(posedge clk) begin
        if (push && !flush && !reset) begin
            mem_r[tail_r] <= din;
        end
    end

    assign head  = mem_r[head_r];
    assign count = count_r;

endmodule

// File: rtl/fetch_queued.sv
// Queued fetch stage: owns the PC and instruction memory, fills a prefetch queue
// one word per cycle and hands its head to decode; a redirect flushes and restarts.
module fetch_queued
    import fetch_pkg::*;
#(
    parameter int              WORD       = 32,
    parameter int              IMEM_POWER = 18,
    parameter int              QDEPTH     = 4,
    parameter logic [WORD-1:0] RESET_PC   = '0
) (
    input  logic             clk,
    input  logic             reset,
    fetch_queued_if.master   fq
);
    localparam int CNT_W = $clog2(QDEPTH+1);

    logic [WORD-1:0]  pc;
    logic [WORD-1:0]  RAM [0:(2**IMEM_POWER)-1];

    logic [CNT_W-1:0] count_s;
    fetch_entry_t     head_s;
    fetch_entry_t     fill_s;
    logic             valid_s;
    logic             pop_s;
    logic             push_s;

    // Handshake decode; a redirect suppresses both pop and push for the cycle.
    always_comb begin
        valid_s      = (count_s != {CNT_W{1'b0}});
        pop_s        = valid_s && !fq.stallD && !fq.PCSrcM;
        push_s       = !fq.PCSrcM && ((count_s < CNT_W'(QDEPTH)) || pop_s);
        fill_s.pc    = pc;
        fill_s.instr = RAM[pc[IMEM_POWER+1:2]];
    end

    // PC update: redirect first, then advance only when the fetched word was queued.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (fq.PCSrcM) begin
            pc <= align_pc(fq.pcM);
        end else if (push_s) begin
            pc <= pc + WORD'(INSTR_BYTES);
        end else begin
            pc <= pc;
        end
    end

    fetch_queue #(
        .QDEPTH (QDEPTH)
    ) u_queue (
        .clk   (clk),
        .reset (reset),
        .flush (fq.PCSrcM),
        .push  (push_s),
        .pop   (pop_s),
        .din   (fill_s),
        .head  (head_s),
        .count (count_s)
    );

    assign fq.validD    = valid_s;
    assign fq.pcD       = valid_s ? head_s.pc    : {WORD{1'b0}};
    assign fq.instrD    = valid_s ? head_s.instr : {WORD{1'b0}};
    assign fq.occupancy = count_s;

endmodule

// File: tb/tb_fetch_queued.sv
// Self-checking bench for fetch_queued: a table of per-cycle vectors for the
// directed sequences, a scoreboard run under random stalls, and an index-wrap check.
module tb_fetch_queued;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_queued_if #(.WORD(32), .QDEPTH(4)) fq ();

    fetch_queued dut (
        .clk   (clk),
        .reset (reset),
        .fq    (fq)
    );

    typedef struct {
        logic        rst;
        logic        red;
        logic [31:0] pcm;
        logic        stall;
        logic        ev;
        logic [31:0] epc;
        int          eocc;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] img [0:63];
    logic [31:0] sb[$];
    int          total = 0;
    int          passed = 0;

    function automatic void add(input logic r, input logic rd, input logic [31:0] pm,
                                input logic st, input logic v, input logic [31:0] p, input int oc);
        vec_t e;
        e.rst = r; e.red = rd; e.pcm = pm; e.stall = st; e.ev = v; e.epc = p; e.eocc = oc;
        tbl.push_back(e);
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    endtask

    task automatic drive_step(input logic r, input logic rd, input logic [31:0] pm, input logic st);
        reset = r; fq.PCSrcM = rd; fq.pcM = pm; fq.stallD = st;
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string tag, input int idx, input logic v,
                                 input logic [31:0] p, input logic [31:0] ins, input int oc);
        chk({tag, "_valid"}, idx, {31'd0, fq.validD}, {31'd0, v});
        chk({tag, "_pcD"},   idx, fq.pcD, p);
        chk({tag, "_instr"}, idx, fq.instrD, ins);
        chk({tag, "_occ"},   idx, {29'd0, fq.occupancy}, oc[31:0]);
    endtask

    initial begin
        logic [31:0] mpc;
        logic        st;
        logic        mpop;

        for (int i = 0; i < 64; i++) begin
            img[i] = 32'h0000_0100 + 32'(i);
            dut.RAM[i] = img[i];
        end

        // rst red pcm stall | valid pcD occ
        add(1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  0);   // reset
        add(1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 32'h0,  1);   // first entry
        add(1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 32'h4,  1);
        add(1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 32'h8,  1);
        add(1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 32'hC,  1);
        add(1'b1, 1'b0, 32'h0,  1'b1, 1'b0, 32'h0,  0);   // stall from reset
        add(1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h0,  1);
        add(1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h0,  2);
        add(1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h0,  3);
        add(1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h0,  4);
        add(1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h0,  4);   // full + stall holds
        add(1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h0,  4);
        add(1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 32'h4,  4);   // drain while full
        add(1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 32'h8,  4);
        add(1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 32'hC,  4);
        add(1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 32'h10, 4);
        add(1'b1, 1'b0, 32'h0,  1'b1, 1'b0, 32'h0,  0);   // build occupancy 3
        add(1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h0,  1);
        add(1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h0,  2);
        add(1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h0,  3);
        add(1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0,  0);   // redirect, pop pending
        add(1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h40, 1);
        add(1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 32'h44, 1);
        add(1'b0, 1'b1, 32'h43, 1'b0, 1'b0, 32'h0,  0);   // misaligned target
        add(1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 32'h40, 1);
        add(1'b0, 1'b1, 32'h80, 1'b0, 1'b0, 32'h0,  0);   // back-to-back redirects
        add(1'b0, 1'b1, 32'hC0, 1'b0, 1'b0, 32'h0,  0);
        add(1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 32'hC0, 1);
        add(1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'hC0, 2);
        add(1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'hC0, 3);
        add(1'b1, 1'b0, 32'h0,  1'b1, 1'b0, 32'h0,  0);   // mid-stream reset
        add(1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 32'h0,  1);
        add(1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 32'h4,  1);
        add(1'b1, 1'b1, 32'h80, 1'b0, 1'b0, 32'h0,  0);   // reset drops redirect
        add(1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 32'h0,  1);

        foreach (tbl[i]) begin
            drive_step(tbl[i].rst, tbl[i].red, tbl[i].pcm, tbl[i].stall);
            check_outputs("vec", i, tbl[i].ev, tbl[i].epc,
                          tbl[i].ev ? img[tbl[i].epc[7:2]] : 32'h0, tbl[i].eocc);
        end

        // Scoreboard under random stalls: fetched PCs queue up, decode pops the head.
        drive_step(1'b1, 1'b0, 32'h0, 1'b0);
        mpc = 32'h0;
        for (int c = 0; c < 60; c++) begin
            st   = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
            if (c > 40) st = 1'b0;
            mpop = (sb.size() != 0) && !st;
            if (mpop) void'(sb.pop_front());
            if (sb.size() < 4) begin
                sb.push_back(mpc);
                mpc = mpc + 32'd4;
            end
            drive_step(1'b0, 1'b0, 32'h0, st);
            if (c % 8 == 0 || c > 52) begin
                check_outputs("sb", c, 1'b1, sb[0], img[sb[0][7:2]], sb.size());
            end
        end

        // Index wraps: a target of 4*2^IMEM_POWER reads RAM[0].
        img[0] = 32'h0000_00AA;
        dut.RAM[0] = img[0];
        drive_step(1'b0, 1'b1, 32'h0010_0000, 1'b1);
        chk("wrap_flush", 0, {31'd0, fq.validD}, 32'h0);
        drive_step(1'b0, 1'b0, 32'h0, 1'b1);
        check_outputs("wrap", 1, 1'b1, 32'h0010_0000, 32'h0000_00AA, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
